gb_timer: RTL



---
 rtl/gb_timer.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/gb_timer.sv
// DMG-style DIV/TIMA/TMA/TAC timer with a falling-edge tick detector and delayed TMA reload.
// state  | meaning
// RUN    | normal counting, TIMA increments on each tick
// OVF    | TIMA overflowed, holds 00 while the reload delay runs down
// RELOAD | TIMA takes TMA, irq_timer high for this clock only
module gb_timer #(
  parameter int RELOAD_DELAY = 4,
  parameter int CNT_W        = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] A,
  input  logic [7:0]  Di,
  output logic [7:0]  Do,
  input  logic        cs,
  input  logic        wr,
  input  logic        rd,
  output logic        irq_timer
);

  localparam int DLY_W = (RELOAD_DELAY > 1) ? $clog2(RELOAD_DELAY) : 1;
  localparam logic [DLY_W-1:0] DLY_INIT = DLY_W'(RELOAD_DELAY - 1);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_OVF    = 2'd1,
    ST_RELOAD = 2'd2
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       tima_q;
  logic [7:0]       tma_q, tma_d;
  logic [2:0]       tac_q, tac_d;
  logic [DLY_W-1:0] dly_q;
  logic             t_q;
  logic             irq_q;

  logic        wr_en, wr_div, wr_tima, wr_tma, wr_tac;
  logic        sel, t_in, tick;
  logic [15:0] cnt16;
  logic        unused_ok;

  assign wr_en   = cs & wr;
  assign wr_div  = wr_en & (A[1:0] == 2'd0);
  assign wr_tima = wr_en & (A[1:0] == 2'd1);
  assign wr_tma  = wr_en & (A[1:0] == 2'd2);
  assign wr_tac  = wr_en & (A[1:0] == 2'd3);

  always_comb begin
    sel = 1'b0;
    case (tac_q[1:0])
      2'b00:   sel = cnt_q[9];
      2'b01:   sel = cnt_q[3];
      2'b10:   sel = cnt_q[5];
      default: sel = cnt_q[7];
    endcase
  end

  // Falling edge of the gated divider bit; DIV or TAC writes can produce it too.
  assign t_in = tac_q[2] & sel;
  assign tick = t_q & ~t_in;

  assign cnt_d = wr_div ? '0 : cnt_q + 1'b1;
  assign tma_d = wr_tma ? Di : tma_q;
  assign tac_d = wr_tac ? Di[2:0] : tac_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      tma_q <= 8'h00;
      tac_q <= 3'b000;
      t_q   <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tma_q <= tma_d;
      tac_q <= tac_d;
      t_q   <= t_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      tima_q  <= 8'h00;
      dly_q   <= '0;
      irq_q   <= 1'b0;
    end else begin
      irq_q <= 1'b0;
      case (state_q)
        ST_RUN: begin
          if (wr_tima) begin
            tima_q <= Di;
          end else if (tick) begin
            if (tima_q == 8'hFF) begin
              tima_q  <= 8'h00;
              dly_q   <= DLY_INIT;
              state_q <= ST_OVF;
            end else begin
              tima_q <= tima_q + 8'd1;
            end
          end
        end
        ST_OVF: begin
          if (wr_tima) begin
            tima_q  <= Di;
            state_q <= ST_RUN;
          end else if (dly_q == '0) begin
            state_q <= ST_RELOAD;
            irq_q   <= 1'b1;
          end else begin
            dly_q <= dly_q - 1'b1;
          end
        end
        ST_RELOAD: begin
          // TMA written this same cycle is forwarded; CPU TIMA writes lose here.
          tima_q  <= tma_d;
          state_q <= ST_RUN;
        end
        default: state_q <= ST_RUN;
      endcase
    end
  end

  assign irq_timer = irq_q;
  assign cnt16     = 16'(cnt_q);

  always_comb begin
    Do = 8'h00;
    if (cs & rd) begin
      case (A[1:0])
        2'd0:    Do = cnt16[15:8];
        2'd1:    Do = tima_q;
        2'd2:    Do = tma_q;
        default: Do = {5'b11111, tac_q};
      endcase
    end
  end

  assign unused_ok = ^{A[15:2], cnt16[7:0]};

endmodule
